// File: rtl/cb_cfg_loader.sv
// cb_cfg_loader: ID-addressed bit-serial configuration loader for one connection block
//
// Frames arrive on a daisy-chained serial bus: ID_WIDTH ID bits (MSB first),
// then CFG_SIZE payload bits (first payload bit ends up in cfg[0]).
// A frame whose ID equals ID (or is all-ones, broadcast) is shifted into a
// staging register and copied to cfg in a single cycle, so the cb muxes never
// see a partially loaded vector. Every input bit is forwarded one cycle late.
//
// Optional feature macro: CB_CFG_PARITY_EN
//   Adds one even-parity bit after the payload and the cfg_perr output. A frame
//   with bad parity leaves cfg untouched and pulses cfg_perr instead of cfg_done.
//
// Ports:
//   clk            in   1         fabric/config clock
//   rst_n          in   1         async active-low reset (released synchronously)
//   cfg_in_start   in   1         1-cycle pulse alongside the first ID bit
//   cfg_bit_in     in   1         serial config data
//   cfg_out_start  out  1         cfg_in_start delayed 1 cycle
//   cfg_bit_out    out  1         cfg_bit_in delayed 1 cycle
//   cfg            out  CFG_SIZE  committed config vector
//   cfg_busy       out  1         high while a frame is in progress
//   cfg_done       out  1         1-cycle pulse when cfg is updated
//   cfg_perr       out  1         1-cycle pulse on parity failure (CB_CFG_PARITY_EN only)
module cb_cfg_loader #(
    parameter int CFG_SIZE = 256,
    parameter int ID_WIDTH = 3,
    parameter int ID       = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_in_start,
    input  logic                cfg_bit_in,
    output logic                cfg_out_start,
    output logic                cfg_bit_out,
    output logic [CFG_SIZE-1:0] cfg,
    output logic                cfg_busy,
`ifdef CB_CFG_PARITY_EN
    output logic                cfg_done,
    output logic                cfg_perr
`else
    output logic                cfg_done
`endif
);
    localparam int CW = $clog2(CFG_SIZE + 1);
`ifdef CB_CFG_PARITY_EN
    localparam int PL_BITS = CFG_SIZE + 1;
`else
    localparam int PL_BITS = CFG_SIZE;
`endif
    localparam logic [CW-1:0]       ID_LAST = CW'(ID_WIDTH - 1);
    localparam logic [CW-1:0]       PL_LAST = CW'(PL_BITS - 1);
    localparam logic [CW-1:0]       PL_DATA = CW'(CFG_SIZE);
    localparam logic [ID_WIDTH-1:0] MY_ID   = ID_WIDTH'(ID);

    typedef enum logic [2:0] {S_IDLE, S_ID, S_LOAD, S_SKIP, S_COMMIT} state_t;

    state_t                state, nxt;
    logic   [1:0]          rst_q;
    logic                  rst_s;
    logic   [CW-1:0]       cnt;
    logic   [ID_WIDTH-1:0] id_sr, id_field;
    logic   [CFG_SIZE-1:0] stage;
    logic                  id_hit, last_id, last_pl;
    logic                  shift_en, cnt_run, commit, commit_ok;

    // Reset asserts immediately but is released only after two clean clock
    // edges, so no flop leaves reset on a partial cycle.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rst_q <= 2'b00;
        else        rst_q <= {rst_q[0], 1'b1};
    assign rst_s = rst_q[1];

    // The ID decision is made while the last ID bit is still on the input,
    // so the field is the bits collected so far plus the live bit.
    assign id_field = {id_sr[ID_WIDTH-2:0], cfg_bit_in};
    assign id_hit   = (id_field == MY_ID) || (&id_field);
    assign last_id  = cnt == ID_LAST;
    assign last_pl  = cnt == PL_LAST;

    // State register
    always_ff @(posedge clk or negedge rst_s)
        if (!rst_s) state <= S_IDLE;
        else        state <= nxt;

    // Next-state logic; a start pulse always restarts ID collection,
    // aborting whatever frame was in progress.
    always_comb begin
        nxt = state;
        if (cfg_in_start) nxt = S_ID;
        else
            case (state)
                S_ID:     nxt = last_id ? (id_hit ? S_LOAD : S_SKIP) : S_ID;
                S_LOAD:   nxt = last_pl ? S_COMMIT : S_LOAD;
                S_SKIP:   nxt = last_pl ? S_IDLE : S_SKIP;
                S_COMMIT: nxt = S_IDLE;
                default:  nxt = S_IDLE;
            endcase
    end

    // Output / control decode
    always_comb begin
        cfg_busy = state != S_IDLE;
        shift_en = (state == S_LOAD) && (cnt < PL_DATA);
        cnt_run  = (state == S_ID) || (state == S_LOAD) || (state == S_SKIP);
        commit   = state == S_COMMIT;
    end

    // Field bit counter: starts at 1 because the start cycle already carries
    // the ID MSB; cleared when each field ends so it never wraps.
    always_ff @(posedge clk or negedge rst_s)
        if (!rst_s)            cnt <= '0;
        else if (cfg_in_start) cnt <= CW'(1);
        else if (cnt_run)      cnt <= ((state == S_ID) ? last_id : last_pl) ? '0 : cnt + CW'(1);
        else                   cnt <= '0;

    always_ff @(posedge clk or negedge rst_s)
        if (!rst_s)                              id_sr <= '0;
        else if (cfg_in_start || state == S_ID) id_sr <= id_field;

    always_ff @(posedge clk or negedge rst_s)
        if (!rst_s)        stage <= '0;
        else if (shift_en) stage <= {cfg_bit_in, stage[CFG_SIZE-1:1]};

`ifdef CB_CFG_PARITY_EN
    logic par;

    // Running XOR over payload and parity bit; zero means even parity.
    always_ff @(posedge clk or negedge rst_s)
        if (!rst_s)              par <= 1'b0;
        else if (cfg_in_start)   par <= 1'b0;
        else if (state == S_LOAD) par <= par ^ cfg_bit_in;

    assign commit_ok = commit && !par;

    always_ff @(posedge clk or negedge rst_s)
        if (!rst_s) cfg_perr <= 1'b0;
        else        cfg_perr <= commit && par;
`else
    assign commit_ok = commit;
`endif

    // The commit still completes if a new start arrives in the COMMIT cycle:
    // the start only touches the ID path, never stage or cfg.
    always_ff @(posedge clk or negedge rst_s)
        if (!rst_s) begin
            cfg      <= '0;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= commit_ok;
            if (commit_ok) cfg <= stage;
        end

    // Chain forwarding is unconditional.
    always_ff @(posedge clk or negedge rst_s)
        if (!rst_s) begin
            cfg_out_start <= 1'b0;
            cfg_bit_out   <= 1'b0;
        end else begin
            cfg_out_start <= cfg_in_start;
            cfg_bit_out   <= cfg_bit_in;
        end
endmodule
